// File: rtl/rename_pkg.sv
// Shared types, constants and decode helpers for the RV32E rename/dispatch stage.
package rename_pkg;

  localparam int ARCH_REGS = 16;
  localparam int PHYS_REGS = 32;
  localparam int FL_DEPTH  = PHYS_REGS - ARCH_REGS;

  typedef logic [4:0] tag_t;
  typedef logic [3:0] arch_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Registered output slot presented to the reservation station.
  typedef struct packed {
    logic        alloc;
    logic [31:0] pc;
    logic [31:0] inst;
    tag_t        prs1;
    tag_t        prs2;
    tag_t        prd;
    tag_t        old_prd;
    logic        prs1_valid;
    logic        prs2_valid;
  } slot_t;

  // Writes to x0 never allocate a tag; STORE/BRANCH/unknown opcodes have no rd.
  function automatic logic writes_rd(input logic [6:0] opcode, input arch_t rd);
    logic op_ok;
    case (opcode)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI,
      OPC_AUIPC, OPC_JAL, OPC_JALR: op_ok = 1'b1;
      default:                      op_ok = 1'b0;
    endcase
    return op_ok && (rd != 4'd0);
  endfunction

endpackage

// File: rtl/rename_free_list.sv
// Circular FIFO of free physical tags; resets holding P16..P31 with P16 at the head.
module rename_free_list
  import rename_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       push_i,
  input  tag_t       push_tag_i,
  input  logic       pop_i,
  output tag_t       head_o,
  output logic [4:0] count_o
);

  tag_t       mem_q [FL_DEPTH];
  logic [3:0] head_q, tail_q;
  logic [4:0] count_q;
  logic       empty, full, push_ok, pop_ok;

  assign empty   = (count_q == 5'd0);
  assign full    = (count_q == 5'(FL_DEPTH));
  assign push_ok = push_i && !full;
  assign pop_ok  = pop_i && !empty;
  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

  // 4-bit pointers wrap naturally at FL_DEPTH; tail starts at 0 because the list is full.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        mem_q[i] <= tag_t'(ARCH_REGS + i);
      end
      head_q  <= 4'd0;
      tail_q  <= 4'd0;
      count_q <= 5'(FL_DEPTH);
    end else begin
      if (push_ok) begin
        mem_q[tail_q] <= push_tag_i;
        tail_q        <= tail_q + 4'd1;
      end
      if (pop_ok) begin
        head_q <= head_q + 4'd1;
      end
      count_q <= count_q + 5'(push_ok) - 5'(pop_ok);
    end
  end

  overflow_push: assert property (@(posedge clk_i) disable iff (!reset_ni) !(push_i && full));

endmodule

// File: rtl/rename_dispatch.sv
// In-order rename/dispatch: maps x0..x15 to 32 physical tags, tracks busy tags from the CDB,
// and presents one renamed instruction per cycle through a registered slot to the RS.
module rename_dispatch
  import rename_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        dec_valid_i,
  output logic        dec_ready_o,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  input  logic        rs_free_i,
  output logic        rs_allocate_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic [4:0]  prs1_addr_o,
  output logic [4:0]  prs2_addr_o,
  output logic [4:0]  prd_addr_o,
  output logic [4:0]  old_prd_o,
  output logic        prs1_valid_o,
  output logic        prs2_valid_o,
  input  logic        cdb_en_i,
  input  logic [4:0]  cdb_tag_i,
  input  logic        commit_en_i,
  input  logic [4:0]  commit_old_prd_i
);

  // Handshake: an instruction transfers when dec_valid_i && dec_ready_o at a rising edge;
  // the slot transfers to the RS when rs_allocate_o && rs_free_i at a rising edge.

  tag_t                 rat_q [ARCH_REGS];
  logic [PHYS_REGS-1:0] busy_q, busy_d;
  slot_t                slot_q, slot_d;

  arch_t      rs1_a, rs2_a, rd_a;
  tag_t       rs1_tag, rs2_tag, old_tag, fl_head;
  logic [4:0] fl_count;
  logic       wr, advance, fire, alloc_rd, commit_push;
  logic       rs1_rdy, rs2_rdy;

  assign rs1_a = inst_i[18:15];
  assign rs2_a = inst_i[23:20];
  assign rd_a  = inst_i[10:7];

  assign wr          = writes_rd(inst_i[6:0], rd_a);
  assign advance     = !slot_q.alloc || rs_free_i;
  assign dec_ready_o = advance && (!wr || (fl_count != 5'd0));
  assign fire        = dec_valid_i && dec_ready_o;
  assign alloc_rd    = fire && wr;
  assign commit_push = commit_en_i && (commit_old_prd_i != 5'd0);

  // RAT is read combinationally before this cycle's rd update, so rs1==rd sees the old tag.
  assign rs1_tag = rat_q[rs1_a];
  assign rs2_tag = rat_q[rs2_a];
  assign old_tag = rat_q[rd_a];

  assign rs1_rdy = (rs1_tag == 5'd0) || !busy_q[rs1_tag] || (cdb_en_i && (cdb_tag_i == rs1_tag));
  assign rs2_rdy = (rs2_tag == 5'd0) || !busy_q[rs2_tag] || (cdb_en_i && (cdb_tag_i == rs2_tag));

  rename_free_list u_free_list (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .push_i     (commit_push),
    .push_tag_i (commit_old_prd_i),
    .pop_i      (alloc_rd),
    .head_o     (fl_head),
    .count_o    (fl_count)
  );

  always_comb begin
    slot_d = slot_q;
    if (fire) begin
      slot_d.alloc      = 1'b1;
      slot_d.pc         = pc_i;
      slot_d.inst       = inst_i;
      slot_d.prs1       = rs1_tag;
      slot_d.prs2       = rs2_tag;
      slot_d.prs1_valid = rs1_rdy;
      slot_d.prs2_valid = rs2_rdy;
      slot_d.prd        = alloc_rd ? fl_head : 5'd0;
      slot_d.old_prd    = alloc_rd ? old_tag : 5'd0;
    end else if (advance) begin
      slot_d.alloc = 1'b0;
    end else begin
      // Held slot keeps snooping the CDB so a wakeup during the stall is not lost.
      if (cdb_en_i && (cdb_tag_i == slot_q.prs1)) slot_d.prs1_valid = 1'b1;
      if (cdb_en_i && (cdb_tag_i == slot_q.prs2)) slot_d.prs2_valid = 1'b1;
    end
  end

  // Allocation is applied after the CDB clear so a same-cycle allocate of that tag wins.
  always_comb begin
    busy_d = busy_q;
    if (cdb_en_i && (cdb_tag_i != 5'd0)) busy_d[cdb_tag_i] = 1'b0;
    if (alloc_rd) busy_d[fl_head] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        rat_q[i] <= tag_t'(i);
      end
      busy_q <= '0;
      slot_q <= '0;
    end else begin
      if (alloc_rd) rat_q[rd_a] <= fl_head;
      busy_q <= busy_d;
      slot_q <= slot_d;
    end
  end

  assign rs_allocate_o = slot_q.alloc;
  assign pc_o          = slot_q.pc;
  assign inst_o        = slot_q.inst;
  assign prs1_addr_o   = slot_q.prs1;
  assign prs2_addr_o   = slot_q.prs2;
  assign prd_addr_o    = slot_q.prd;
  assign old_prd_o     = slot_q.old_prd;
  assign prs1_valid_o  = slot_q.prs1_valid;
  assign prs2_valid_o  = slot_q.prs2_valid;

endmodule
